// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the FSM encoding, the scoreboard entry layout and the source-match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       ld;
        logic [2:0] dst;
    } sb_entry_t;

    localparam int        SB_ENTRY_W  = 6;
    localparam logic [1:0] DRAIN_DEPTH = 2'd3;
    localparam sb_entry_t SB_EMPTY    = 6'b000000;

    // A source depends on an entry only if both sides are live and the register numbers agree.
    function automatic logic src_match(input logic src_valid, input logic [2:0] src,
                                       input sb_entry_t e);
        return src_valid & e.v & e.rw & (e.dst == src);
    endfunction

endpackage

// File: rtl/hazard_sb.sv
// Three-entry destination scoreboard shadowing EX, MEM and WB.
// Reports per-stage source hits and load flags as {wb, mem, ex} vectors.
module hazard_sb
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  sb_entry_t  id_entry,
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic       id_rs_valid,
    input  logic       id_rt_valid,
    output logic [2:0] hit,
    output logic [2:0] is_load
);

    sb_entry_t sb_ex_q, sb_ex_d;
    sb_entry_t sb_mem_q, sb_mem_d;
    sb_entry_t sb_wb_q, sb_wb_d;

    // Shift the scoreboard along with the pipeline, hold otherwise.
    always_comb begin
        sb_ex_d  = sb_ex_q;
        sb_mem_d = sb_mem_q;
        sb_wb_d  = sb_wb_q;
        if (advance) begin
            sb_wb_d  = sb_mem_q;
            sb_mem_d = sb_ex_q;
            sb_ex_d  = id_entry;
        end else begin
            sb_ex_d  = sb_ex_q;
        end
    end

    // Scoreboard registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_ex_q  <= SB_EMPTY;
            sb_mem_q <= SB_EMPTY;
            sb_wb_q  <= SB_EMPTY;
        end else begin
            sb_ex_q  <= sb_ex_d;
            sb_mem_q <= sb_mem_d;
            sb_wb_q  <= sb_wb_d;
        end
    end

    assign hit[0] = src_match(id_rs_valid, id_rs, sb_ex_q)  | src_match(id_rt_valid, id_rt, sb_ex_q);
    assign hit[1] = src_match(id_rs_valid, id_rs, sb_mem_q) | src_match(id_rt_valid, id_rt, sb_mem_q);
    assign hit[2] = src_match(id_rs_valid, id_rs, sb_wb_q)  | src_match(id_rt_valid, id_rt, sb_wb_q);
    assign is_load = {sb_wb_q.ld, sb_mem_q.ld, sb_ex_q.ld};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RAW stalls, redirect flushes, memory stalls
// and halt draining for the 5-stage 16-bit core.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter bit FORWARDING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_valid,
    input  logic        id_rt_valid,
    input  logic        id_reg_write,
    input  logic [2:0]  id_write_reg,
    input  logic        id_mem_read,
    input  logic        id_halt,
    input  logic        ex_redirect,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_en,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    // With forwarding only a load in EX can stall; without it any producer in EX or MEM can.
    localparam logic [2:0] RAW_STAGES = FORWARDING ? 3'b001 : 3'b011;
    localparam logic [2:0] NEED_LOAD  = FORWARDING ? 3'b001 : 3'b000;

    hz_state_e   state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  sb_hit_s, sb_ld_s;
    logic        raw_s;
    logic        stall_evt_s;
    sb_entry_t   id_entry_s;

    assign id_entry_s = '{v: id_valid & ~idex_bubble, rw: id_reg_write,
                          ld: id_mem_read, dst: id_write_reg};

    hazard_sb u_sb (
        .clk         (clk),
        .rst         (rst),
        .advance     (pipe_en),
        .id_entry    (id_entry_s),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_valid (id_rs_valid),
        .id_rt_valid (id_rt_valid),
        .hit         (sb_hit_s),
        .is_load     (sb_ld_s)
    );

    assign raw_s        = id_valid & (|(sb_hit_s & RAW_STAGES & (~NEED_LOAD | sb_ld_s)));
    assign stall_cycles = stall_cnt_q;

    // Priority resolution, FSM next state and drain counting.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b1;
        halted      = 1'b0;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_evt_s = 1'b0;
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pipe_en     = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dmem_stall) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        pipe_en     = 1'b0;
                        stall_evt_s = 1'b1;
                    end else if (ex_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (raw_s) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        stall_evt_s = 1'b1;
                    end else begin
                        if (imem_stall) begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                        end else begin
                            ifid_flush = 1'b0;
                        end
                        // HALT is advancing into EX: start draining it out of the pipe.
                        if (id_valid && id_halt) begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = 2'd0;
                        end else begin
                            state_d     = ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    pipe_en     = ~dmem_stall;
                    if (!dmem_stall) begin
                        drain_cnt_d = drain_cnt_q + 2'd1;
                        if (drain_cnt_d == DRAIN_DEPTH) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        drain_cnt_d = drain_cnt_q;
                    end
                end
                ST_HALTED: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b0;
                    halted      = 1'b1;
                end
                default: begin
                    // Unreachable encoding: freeze until reset.
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    pipe_en     = 1'b0;
                    state_d     = ST_HALTED;
                end
            endcase
        end
    end

    // Saturating stall counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_evt_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 2'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
